// File: rtl/pipe_in_check_param_if.sv
// Pipe-in endpoint handshake bundle: write strobe, data, ready.
// master = endpoint side, slave = checker side.
interface pipe_in_check_param_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  pipe_in_write;
  logic [DATA_WIDTH-1:0] pipe_in_data;
  logic                  pipe_in_ready;

  modport master (
    output pipe_in_write,
    output pipe_in_data,
    input  pipe_in_ready
  );

  modport slave (
    input  pipe_in_write,
    input  pipe_in_data,
    output pipe_in_ready
  );
endinterface

// File: rtl/pipe_in_check_param.sv
// Pipe-in data checker: counter/PRBS compare, throttled ready, error stats.
// Optional first-error capture enabled by defining PIPE_CHECK_FIRST_ERR_EN.
module pipe_in_check_param #(
  parameter int          DATA_WIDTH    = 16,
  parameter int          ERR_CNT_WIDTH = 16,
  parameter logic [31:0] LFSR_SEED     = 32'h0D0C_0B0A
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     throttle_set,
  input  logic [31:0]              throttle_val,
  pipe_in_check_param_if.slave     pipe,
  output logic [ERR_CNT_WIDTH-1:0] error_count,
  output logic [31:0]              word_count,
  output logic                     protocol_err
`ifdef PIPE_CHECK_FIRST_ERR_EN
  ,
  output logic                     first_err_valid,
  output logic [31:0]              first_err_index,
  output logic [DATA_WIDTH-1:0]    first_err_data,
  output logic [DATA_WIDTH-1:0]    first_err_expected
`endif
);

  localparam int REP = (DATA_WIDTH + 31) / 32;
  localparam logic [DATA_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = 1;

  logic [31:0]           throttle;
  logic                  ready_q;
  logic [31:0]           lfsr;
  logic [31:0]           lfsr_nxt;
  logic [REP*32-1:0]     lfsr_rep;
  logic [DATA_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] expected;
  logic                  mismatch;

  assign lfsr_nxt = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign lfsr_rep = {REP{lfsr}};
  assign expected = mode ? lfsr_rep[DATA_WIDTH-1:0] : cnt;
  assign mismatch = pipe.pipe_in_write &&
                    (pipe.pipe_in_data != expected);

  assign pipe.pipe_in_ready = ready_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      throttle     <= 32'hFFFF_FFFF;
      ready_q      <= 1'b0;
      error_count  <= '0;
      word_count   <= '0;
      protocol_err <= 1'b0;
      cnt          <= CNT_ONE;
      lfsr         <= LFSR_SEED;
    end else begin
      throttle <= throttle_set ? throttle_val
                               : {throttle[0], throttle[31:1]};
      ready_q  <= throttle[0];
      if (pipe.pipe_in_write) begin
        word_count <= word_count + 32'd1;
        if (mismatch && (error_count != '1))
          error_count <= error_count + ERR_ONE;
        // Violating writes are still checked; only the flag records them
        if (!ready_q)
          protocol_err <= 1'b1;
        if (mode)
          lfsr <= lfsr_nxt;
        else
          cnt <= cnt + CNT_ONE;
      end
    end
  end

`ifdef PIPE_CHECK_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_valid    <= 1'b0;
      first_err_index    <= '0;
      first_err_data     <= '0;
      first_err_expected <= '0;
    end else if (mismatch && !first_err_valid) begin
      first_err_valid    <= 1'b1;
      first_err_index    <= word_count;
      first_err_data     <= pipe.pipe_in_data;
      first_err_expected <= expected;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_in_check_param.sv
// Bench for pipe_in_check_param: 16-bit/4-bit-err and 64-bit/16-bit-err
// instances checked against a sequence model of counter and PRBS words.
module tb_pipe_in_check_param;

  localparam logic [31:0] SEED = 32'h0D0C_0B0A;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        mode16 = 1'b0;
  logic        ts16   = 1'b0;
  logic [31:0] tv16   = '0;
  logic [3:0]  ec16;
  logic [31:0] wc16;
  logic        pe16;

  logic        mode64 = 1'b0;
  logic        ts64   = 1'b0;
  logic [31:0] tv64   = '0;
  logic [15:0] ec64;
  logic [31:0] wc64;
  logic        pe64;

`ifdef PIPE_CHECK_FIRST_ERR_EN
  logic        fv16, fv64;
  logic [31:0] fi16, fi64;
  logic [15:0] fd16, fe16;
  logic [63:0] fd64, fe64;
`endif

  pipe_in_check_param_if #(.DATA_WIDTH(16)) p16 ();
  pipe_in_check_param_if #(.DATA_WIDTH(64)) p64 ();

  pipe_in_check_param #(
    .DATA_WIDTH(16), .ERR_CNT_WIDTH(4), .LFSR_SEED(SEED)
  ) dut16 (
    .clk(clk), .reset(rst), .mode(mode16),
    .throttle_set(ts16), .throttle_val(tv16), .pipe(p16),
    .error_count(ec16), .word_count(wc16), .protocol_err(pe16)
`ifdef PIPE_CHECK_FIRST_ERR_EN
    , .first_err_valid(fv16), .first_err_index(fi16),
    .first_err_data(fd16), .first_err_expected(fe16)
`endif
  );

  pipe_in_check_param #(
    .DATA_WIDTH(64), .ERR_CNT_WIDTH(16), .LFSR_SEED(SEED)
  ) dut64 (
    .clk(clk), .reset(rst), .mode(mode64),
    .throttle_set(ts64), .throttle_val(tv64), .pipe(p64),
    .error_count(ec64), .word_count(wc64), .protocol_err(pe64)
`ifdef PIPE_CHECK_FIRST_ERR_EN
    , .first_err_valid(fv64), .first_err_index(fi64),
    .first_err_data(fd64), .first_err_expected(fe64)
`endif
  );

  // PRBS sequence rule: shift left, feedback from taps 31,21,1,0
  function automatic logic [31:0] prbs_next(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    p16.pipe_in_write = 1'b0;
    p64.pipe_in_write = 1'b0;
    p16.pipe_in_data  = '0;
    p64.pipe_in_data  = '0;
    ts16 = 1'b0;
    ts64 = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (ec16 !== 4'd0 || wc16 !== 32'd0 || pe16 !== 1'b0) begin
      bad++;
      $display("FAIL reset16: ec=%0h wc=%0h pe=%0b want 0 0 0",
               ec16, wc16, pe16);
    end
    total++;
    if (ec64 !== 16'd0 || wc64 !== 32'd0 || pe64 !== 1'b0) begin
      bad++;
      $display("FAIL reset64: ec=%0h wc=%0h pe=%0b want 0 0 0",
               ec64, wc64, pe64);
    end
    total++;
    if (p16.pipe_in_ready !== 1'b0 || p64.pipe_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got %0b/%0b want 0/0",
               p16.pipe_in_ready, p64.pipe_in_ready);
    end
`ifdef PIPE_CHECK_FIRST_ERR_EN
    total++;
    if (fv64 !== 1'b0 || fi64 !== 32'd0 || fd64 !== 64'd0 ||
        fe64 !== 64'd0) begin
      bad++;
      $display("FAIL reset_first_err: v=%0b i=%0h want 0 0", fv64, fi64);
    end
`endif
    rst = 1'b0;
    tick();
    total++;
    if (p16.pipe_in_ready !== 1'b1 || p64.pipe_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset: got %0b/%0b want 1/1",
               p16.pipe_in_ready, p64.pipe_in_ready);
    end
  endtask

  task automatic test_counter16();
    do_reset();
    mode16 = 1'b0;
    for (int i = 1; i <= 1000; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      p16.pipe_in_write = 1'b1;
      p16.pipe_in_data  = 16'(i);
      tick();
      p16.pipe_in_write = 1'b0;
      if (i == 1) begin
        total++;
        if (wc16 !== 32'd1) begin
          bad++;
          $display("FAIL cnt_latency: wc=%0d want 1", wc16);
        end
      end
    end
    tick();
    total++;
    if (ec16 !== 4'd0 || wc16 !== 32'd1000 || pe16 !== 1'b0) begin
      bad++;
      $display("FAIL counter16: ec=%0d wc=%0d pe=%0b want 0 1000 0",
               ec16, wc16, pe16);
    end
  endtask

  task automatic test_prbs64();
    logic [31:0] m;
    logic [63:0] d;
    logic [63:0] d10;
    do_reset();
    mode64 = 1'b1;
    m   = SEED;
    d10 = '0;
    for (int i = 0; i < 256; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      d = {m, m};
      if (i == 10) begin
        d   = d ^ 64'd1;
        d10 = d;
      end
      p64.pipe_in_write = 1'b1;
      p64.pipe_in_data  = d;
      tick();
      p64.pipe_in_write = 1'b0;
      m = prbs_next(m);
    end
    total++;
    if (ec64 !== 16'd1 || wc64 !== 32'd256) begin
      bad++;
      $display("FAIL prbs64: ec=%0d wc=%0d want 1 256", ec64, wc64);
    end
`ifdef PIPE_CHECK_FIRST_ERR_EN
    total++;
    if (fv64 !== 1'b1 || fi64 !== 32'd10 || fd64 !== d10 ||
        fe64 !== (d10 ^ 64'd1)) begin
      bad++;
      $display("FAIL prbs64_first_err: v=%0b i=%0d d=%0h e=%0h want 1 10 %0h %0h",
               fv64, fi64, fd64, fe64, d10, d10 ^ 64'd1);
    end
`endif
  endtask

  task automatic test_sat16();
    do_reset();
    mode16 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      p16.pipe_in_write = 1'b1;
      p16.pipe_in_data  = 16'(i) ^ 16'h8000;
      tick();
      p16.pipe_in_write = 1'b0;
      if (i == 14) begin
        total++;
        if (ec16 !== 4'd14) begin
          bad++;
          $display("FAIL sat_pre: ec=%0d want 14", ec16);
        end
      end
    end
    total++;
    if (ec16 !== 4'hF || wc16 !== 32'd20) begin
      bad++;
      $display("FAIL saturate: ec=%0h wc=%0d want f 20", ec16, wc16);
    end
  endtask

  task automatic test_throttle();
    logic [31:0] val;
    do_reset();
    mode64 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      val  = (r == 0) ? 32'h0000_00F0 : $urandom;
      tv64 = val;
      ts64 = 1'b1;
      // first load coincides with a correct write while ready is high
      if (r == 0) begin
        p64.pipe_in_write = 1'b1;
        p64.pipe_in_data  = 64'd1;
      end
      tick();
      ts64 = 1'b0;
      p64.pipe_in_write = 1'b0;
      for (int k = 1; k <= 64; k++) begin
        tick();
        total++;
        if (p64.pipe_in_ready !== val[(k-1) % 32]) begin
          bad++;
          $display("FAIL throttle k=%0d val=%0h: ready=%0b want %0b",
                   k, val, p64.pipe_in_ready, val[(k-1) % 32]);
        end
      end
    end
    total++;
    if (wc64 !== 32'd1 || ec64 !== 16'd0 || pe64 !== 1'b0) begin
      bad++;
      $display("FAIL throttle_write: wc=%0d ec=%0d pe=%0b want 1 0 0",
               wc64, ec64, pe64);
    end
  endtask

  task automatic test_protocol();
    do_reset();
    mode16 = 1'b0;
    tv16 = 32'h0;
    ts16 = 1'b1;
    tick();
    ts16 = 1'b0;
    tick();
    total++;
    if (p16.pipe_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL proto_ready_low: ready=%0b want 0", p16.pipe_in_ready);
    end
    p16.pipe_in_write = 1'b1;
    p16.pipe_in_data  = 16'd1;
    tick();
    p16.pipe_in_write = 1'b0;
    total++;
    if (pe16 !== 1'b1 || wc16 !== 32'd1 || ec16 !== 4'd0) begin
      bad++;
      $display("FAIL proto_set: pe=%0b wc=%0d ec=%0d want 1 1 0",
               pe16, wc16, ec16);
    end
    tv16 = 32'hFFFF_FFFF;
    ts16 = 1'b1;
    tick();
    ts16 = 1'b0;
    tick();
    for (int i = 2; i <= 11; i++) begin
      p16.pipe_in_write = 1'b1;
      p16.pipe_in_data  = 16'(i);
      tick();
    end
    p16.pipe_in_write = 1'b0;
    total++;
    if (pe16 !== 1'b1 || wc16 !== 32'd11 || ec16 !== 4'd0) begin
      bad++;
      $display("FAIL proto_sticky: pe=%0b wc=%0d ec=%0d want 1 11 0",
               pe16, wc16, ec16);
    end
    do_reset();
    total++;
    if (pe16 !== 1'b0) begin
      bad++;
      $display("FAIL proto_clear: pe=%0b want 0", pe16);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] m;
    int n;
    do_reset();
    mode64 = 1'b1;
    m = SEED;
    for (int i = 0; i < 5; i++) begin
      p64.pipe_in_write = 1'b1;
      p64.pipe_in_data  = {m, m};
      tick();
      m = prbs_next(m);
    end
    total++;
    if (wc64 !== 32'd5) begin
      bad++;
      $display("FAIL mid_pre: wc=%0d want 5", wc64);
    end
    // write held high across the reset edge must be dropped
    rst = 1'b1;
    p64.pipe_in_data = {SEED, SEED};
    tick();
    total++;
    if (wc64 !== 32'd0 || ec64 !== 16'd0) begin
      bad++;
      $display("FAIL mid_reset: wc=%0d ec=%0d want 0 0", wc64, ec64);
    end
    rst = 1'b0;
    p64.pipe_in_write = 1'b0;
    tick();
    m = SEED;
    n = $urandom_range(20, 60);
    for (int i = 0; i < n; i++) begin
      p64.pipe_in_write = 1'b1;
      p64.pipe_in_data  = {m, m};
      tick();
      m = prbs_next(m);
    end
    p64.pipe_in_write = 1'b0;
    total++;
    if (ec64 !== 16'd0 || wc64 !== 32'(n)) begin
      bad++;
      $display("FAIL mid_stream: ec=%0d wc=%0d want 0 %0d", ec64, wc64, n);
    end
  endtask

  task automatic test_random();
    logic [15:0] c16, x16, d16;
    logic [63:0] c64, x64, d64, one;
    logic [31:0] l16, l64;
    int e16, e64, w16, w64;
    logic fv;
    int fi;
    logic [63:0] fd, fe;
    do_reset();
    c16 = 16'd1;  c64 = 64'd1;
    l16 = SEED;   l64 = SEED;
    e16 = 0; e64 = 0; w16 = 0; w64 = 0;
    fv = 1'b0; fi = 0; fd = '0; fe = '0;
    one = 64'd1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) mode16 = ~mode16;
      if ($urandom_range(0, 7) == 0) mode64 = ~mode64;
      x16 = mode16 ? l16[15:0] : c16;
      x64 = mode64 ? {l64, l64} : c64;
      d16 = x16;
      d64 = x64;
      if ($urandom_range(0, 3) == 0)
        d16 = x16 ^ 16'(one << $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        d64 = x64 ^ (one << $urandom_range(0, 63));
      p16.pipe_in_write = ($urandom_range(0, 9) < 7);
      p64.pipe_in_write = ($urandom_range(0, 9) < 7);
      p16.pipe_in_data  = d16;
      p64.pipe_in_data  = d64;
      if (p16.pipe_in_write) begin
        if (d16 != x16 && e16 < 15) e16++;
        if (mode16) l16 = prbs_next(l16);
        else        c16 = c16 + 16'd1;
        w16++;
      end
      if (p64.pipe_in_write) begin
        if (d64 != x64) begin
          if (!fv) begin
            fv = 1'b1; fi = w64; fd = d64; fe = x64;
          end
          e64++;
        end
        if (mode64) l64 = prbs_next(l64);
        else        c64 = c64 + 64'd1;
        w64++;
      end
      tick();
    end
    idle_all();
    total++;
    if (ec16 !== 4'(e16) || wc16 !== 32'(w16) || pe16 !== 1'b0) begin
      bad++;
      $display("FAIL random16: ec=%0d wc=%0d pe=%0b want %0d %0d 0",
               ec16, wc16, pe16, e16, w16);
    end
    total++;
    if (ec64 !== 16'(e64) || wc64 !== 32'(w64) || pe64 !== 1'b0) begin
      bad++;
      $display("FAIL random64: ec=%0d wc=%0d pe=%0b want %0d %0d 0",
               ec64, wc64, pe64, e64, w64);
    end
`ifdef PIPE_CHECK_FIRST_ERR_EN
    total++;
    if (fv64 !== fv || (fv && (fi64 !== 32'(fi) || fd64 !== fd ||
        fe64 !== fe))) begin
      bad++;
      $display("FAIL random_first_err: v=%0b i=%0d want %0b %0d",
               fv64, fi64, fv, fi);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_counter16();
    test_prbs64();
    test_sat16();
    test_throttle();
    test_protocol();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
